// File: rtl/l1_packet_scheduler_pkg.sv
// Shared constants for the L1-current T2-MI packet scheduler.
// L1_LEN_BYTES sets the default L1 body length when it is not given on the command line.
`ifndef L1_LEN_BYTES
`define L1_LEN_BYTES 4
`endif

package l1_packet_scheduler_pkg;
  localparam logic [7:0]  L1_PKT_TYPE   = 8'h10;
  localparam int          L1_HDR_LEN    = 6;
  localparam int          L1_PREFIX_LEN = 2;
  localparam int          L1_CRC_LEN    = 4;
  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HEADER = 3'd1;
  localparam logic [2:0] ST_PREFIX = 3'd2;
  localparam logic [2:0] ST_BODY   = 3'd3;
  localparam logic [2:0] ST_CRC    = 3'd4;

  // One counter indexes every state, so it must span the longer of header and body.
  function automatic int cnt_width(input int len);
    return $clog2(len > L1_HDR_LEN ? len : L1_HDR_LEN);
  endfunction
endpackage

// File: rtl/l1_packet_scheduler_crc32_byte.sv
// Combinational CRC-32 (MSB-first, unreflected) advance by one byte.
// Only present when L1_CRC32_EN is defined.
`ifdef L1_CRC32_EN
module crc32_byte
  import l1_packet_scheduler_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] crc_o
);
  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {byte_i, 24'h0};
    for (int b = 0; b < 8; b++) begin
      c = c[31] ? ((c << 1) ^ CRC32_POLY) : (c << 1);
    end
    crc_o = c;
  end
endmodule
`endif

// File: rtl/l1_packet_scheduler.sv
// Emits a snapshot of the L1 byte bus as a T2-MI L1-current packet, one byte per accepted beat.
// Define L1_CRC32_EN to append a 4-byte CRC-32 trailer.
module l1_packet_scheduler
  import l1_packet_scheduler_pkg::*;
#(
  parameter int L1_LEN   = `L1_LEN_BYTES,
  parameter int SF_IDX_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [8*L1_LEN-1:0]   L1_BUS,
  input  logic                  START,
  input  logic [7:0]            FRAME_IDX,
  input  logic [SF_IDX_W-1:0]   SF_IDX,
  input  logic                  RDY,
  output logic [7:0]            DATA,
  output logic                  VALID,
  output logic                  SOP,
  output logic                  EOP,
  output logic                  BUSY,
  output logic                  START_DROP
);
  localparam int              CNT_W       = cnt_width(L1_LEN);
  localparam logic [15:0]     PLEN        = 16'((2 + L1_LEN) * 8);
  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(L1_HDR_LEN - 1);
  localparam logic [CNT_W-1:0] PREFIX_LAST = CNT_W'(L1_PREFIX_LEN - 1);
  localparam logic [CNT_W-1:0] BODY_LAST  = CNT_W'(L1_LEN - 1);

  logic [2:0]          state_q, state_d, nxt_state;
  logic [CNT_W-1:0]    cnt_q, cnt_d, nxt_cnt;
  logic [7:0]          pkt_cnt_q, pkt_cnt_d;
  logic [7:0]          data_q, data_d, nxt_byte;
  logic                valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, nxt_eop;
  logic                busy_q, busy_d, drop_q, drop_d;
  logic [8*L1_LEN-1:0] l1_q;
  logic [7:0]          fidx_q;
  logic [SF_IDX_W-1:0] sfidx_q;
  logic                acc, take;

  assign acc  = valid_q && RDY;
  assign take = START && !busy_q;

`ifdef L1_CRC32_EN
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(L1_CRC_LEN - 1);
  logic [31:0] crc_q, crc_d, crc_upd, crc_src;
  logic [1:0]  crc_sel;

  crc32_byte u_crc (.crc_i(crc_q), .byte_i(data_q), .crc_o(crc_upd));

  // The trailer is frozen once in ST_CRC; the first CRC byte must see the final body byte.
  assign crc_src = (state_q == ST_CRC) ? crc_q : crc_upd;
  assign crc_sel = 2'd3 - nxt_cnt[1:0];

  always_comb begin
    crc_d = crc_q;
    if (take)                              crc_d = CRC32_INIT;
    else if (acc && (state_q != ST_CRC))   crc_d = crc_upd;
  end

  always_ff @(posedge CLK) crc_q <= crc_d;
`endif

  // Position of the beat that follows the one currently presented, assuming it is accepted.
  always_comb begin
    nxt_state = state_q;
    nxt_cnt   = cnt_q + CNT_W'(1);
    case (state_q)
      ST_HEADER: if (cnt_q == HDR_LAST)    begin nxt_state = ST_PREFIX; nxt_cnt = '0; end
      ST_PREFIX: if (cnt_q == PREFIX_LAST) begin nxt_state = ST_BODY;   nxt_cnt = '0; end
`ifdef L1_CRC32_EN
      ST_BODY:   if (cnt_q == BODY_LAST)   begin nxt_state = ST_CRC;    nxt_cnt = '0; end
      ST_CRC:    if (cnt_q == CRC_LAST)    begin nxt_state = ST_IDLE;   nxt_cnt = '0; end
`else
      ST_BODY:   if (cnt_q == BODY_LAST)   begin nxt_state = ST_IDLE;   nxt_cnt = '0; end
`endif
      default:                             begin nxt_state = ST_IDLE;   nxt_cnt = '0; end
    endcase
  end

  always_comb begin
    nxt_byte = 8'h00;
    case (nxt_state)
      ST_HEADER: begin
        case (int'(nxt_cnt))
          0:       nxt_byte = L1_PKT_TYPE;
          1:       nxt_byte = pkt_cnt_q;
          2:       nxt_byte = 8'({sfidx_q, 4'h0});
          4:       nxt_byte = PLEN[15:8];
          5:       nxt_byte = PLEN[7:0];
          default: nxt_byte = 8'h00;
        endcase
      end
      ST_PREFIX: nxt_byte = (nxt_cnt == '0) ? fidx_q : 8'h00;
      ST_BODY:   nxt_byte = l1_q[{nxt_cnt, 3'b000} +: 8];
`ifdef L1_CRC32_EN
      ST_CRC:    nxt_byte = crc_src[{crc_sel, 3'b000} +: 8];
`endif
      default:   nxt_byte = 8'h00;
    endcase
  end

`ifdef L1_CRC32_EN
  assign nxt_eop = (nxt_state == ST_CRC) && (nxt_cnt == CRC_LAST);
`else
  assign nxt_eop = (nxt_state == ST_BODY) && (nxt_cnt == BODY_LAST);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    busy_d    = busy_q;
    drop_d    = START && busy_q;
    if (take) begin
      state_d = ST_HEADER;
      cnt_d   = '0;
      data_d  = L1_PKT_TYPE;
      valid_d = 1'b1;
      sop_d   = 1'b1;
      eop_d   = 1'b0;
      busy_d  = 1'b1;
    end else if (acc) begin
      state_d = nxt_state;
      cnt_d   = nxt_cnt;
      sop_d   = 1'b0;
      if (nxt_state == ST_IDLE) begin
        valid_d   = 1'b0;
        eop_d     = 1'b0;
        busy_d    = 1'b0;
        pkt_cnt_d = pkt_cnt_q + 8'd1;
      end else begin
        data_d = nxt_byte;
        eop_d  = nxt_eop;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pkt_cnt_q <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  // Snapshot so later bus changes cannot tear the packet in flight.
  always_ff @(posedge CLK) begin
    if (take) begin
      l1_q    <= L1_BUS;
      fidx_q  <= FRAME_IDX;
      sfidx_q <= SF_IDX;
    end
  end

  assign DATA       = data_q;
  assign VALID      = valid_q;
  assign SOP        = sop_q;
  assign EOP        = eop_q;
  assign BUSY       = busy_q;
  assign START_DROP = drop_q;
endmodule

// File: tb/tb_l1_packet_scheduler.sv
// Directed bench for l1_packet_scheduler with a packet-level reference model.
module tb_l1_packet_scheduler;
  localparam int LEN = 4;
`ifdef L1_CRC32_EN
  localparam int PKT_LEN = 6 + 2 + LEN + 4;
`else
  localparam int PKT_LEN = 6 + 2 + LEN;
`endif

  typedef logic [7:0] bq_t[$];

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             START = 1'b0;
  logic             RDY = 1'b1;
  logic [8*LEN-1:0] L1_BUS = 32'h4433_2211;
  logic [7:0]       FRAME_IDX = 8'h07;
  logic [3:0]       SF_IDX = 4'h3;
  logic [7:0]       DATA;
  logic             VALID, SOP, EOP, BUSY, START_DROP;

  int   tests = 0;
  int   fails = 0;
  bit   rdy_toggle = 1'b0;
  bq_t  cap;
  bq_t  mpkt;
  int   midx = 0;
  bit   mvalid = 1'b0;
  bit   mdrop = 1'b0;
  logic [7:0] mcount = 8'h00;
  logic [7:0] lit [12];
  logic [7:0] seen [257];

  l1_packet_scheduler #(.L1_LEN(LEN), .SF_IDX_W(4)) dut (
    .CLK(CLK), .RST(RST), .L1_BUS(L1_BUS), .START(START), .FRAME_IDX(FRAME_IDX),
    .SF_IDX(SF_IDX), .RDY(RDY), .DATA(DATA), .VALID(VALID), .SOP(SOP), .EOP(EOP),
    .BUSY(BUSY), .START_DROP(START_DROP)
  );

  initial forever #5 CLK = ~CLK;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_crc(input bq_t q);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      c ^= {q[i], 24'h0};
      for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
    end
    return c;
  endfunction

  function automatic bq_t build_pkt(input logic [7:0] cnt, input logic [8*LEN-1:0] bus,
                                    input logic [7:0] fidx, input logic [3:0] sf);
    bq_t q;
    int  plen = (2 + LEN) * 8;
    q.push_back(8'h10); q.push_back(cnt); q.push_back({sf, 4'h0}); q.push_back(8'h00);
    q.push_back(plen[15:8]); q.push_back(plen[7:0]);
    q.push_back(fidx); q.push_back(8'h00);
    for (int i = 0; i < LEN; i++) q.push_back(bus[8*i +: 8]);
`ifdef L1_CRC32_EN
    begin
      logic [31:0] c = ref_crc(q);
      for (int k = 3; k >= 0; k--) q.push_back(c[8*k +: 8]);
    end
`endif
    return q;
  endfunction

  // Every cycle: check outputs against the model, then advance the model by the upcoming edge.
  initial begin
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      chk("valid", VALID, mvalid);
      chk("busy", BUSY, mvalid);
      chk("start_drop", START_DROP, mdrop);
      if (mvalid) begin
        chk("data", DATA, mpkt[midx]);
        chk("sop", SOP, midx == 0);
        chk("eop", EOP, midx == PKT_LEN - 1);
      end
      if (VALID && RDY && !RST) cap.push_back(DATA);
      if (RST) begin
        mvalid = 1'b0; mdrop = 1'b0; mcount = 8'h00;
      end else begin
        mdrop = START && mvalid;
        if (START && !mvalid) begin
          mpkt = build_pkt(mcount, L1_BUS, FRAME_IDX, SF_IDX);
          midx = 0;
          mvalid = 1'b1;
        end else if (mvalid && RDY) begin
          midx++;
          if (midx == PKT_LEN) begin
            mvalid = 1'b0;
            mcount++;
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge CLK); #1;
    RDY = rdy_toggle ? ~RDY : 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic pulse_start(input logic [7:0] f, input logic [3:0] s);
    FRAME_IDX = f; SF_IDX = s; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (BUSY && n < 400) begin tick(); n++; end
    chk("done_timeout_busy", BUSY, 1'b0);
  endtask

  task automatic wait_beats(input int k);
    int n = 0;
    while (cap.size() < k && n < 400) begin tick(); n++; end
    chk("beats_timeout", cap.size() >= k, 1'b1);
  endtask

  task automatic check_lit(input string name, input logic [7:0] b1);
    lit = '{8'h10, 8'h00, 8'h30, 8'h00, 8'h00, 8'h30, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    lit[1] = b1;
    chk({name, "_len"}, cap.size(), PKT_LEN);
    for (int i = 0; i < 12; i++) chk(name, (i < cap.size()) ? cap[i] : 8'hxx, lit[i]);
  endtask

  initial begin
    bq_t pin;
    pin = build_pkt(8'h00, 32'h4433_2211, 8'h07, 4'h3);
    lit = '{8'h10, 8'h00, 8'h30, 8'h00, 8'h00, 8'h30, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 12; i++) chk("model_pin", pin[i], lit[i]);

    repeat (3) tick();
    chk("rst_valid", VALID, 1'b0); chk("rst_data", DATA, 8'h00); chk("rst_sop", SOP, 1'b0);
    chk("rst_eop", EOP, 1'b0); chk("rst_busy", BUSY, 1'b0); chk("rst_drop", START_DROP, 1'b0);
    RST = 1'b0;
    tick();

    cap.delete();
    pulse_start(8'h07, 4'h3);
    chk("first_sop", SOP, 1'b1);
    chk("first_data", DATA, 8'h10);
    wait_done();
    check_lit("pkt_basic", 8'h00);

    cap.delete();
    rdy_toggle = 1'b1;
    pulse_start(8'h07, 4'h3);
    wait_done();
    rdy_toggle = 1'b0;
    tick();
    check_lit("pkt_rdy_toggle", 8'h01);

    cap.delete();
    pulse_start(8'h07, 4'h3);
    L1_BUS = 32'hFFFF_FFFF;
    wait_done();
    check_lit("pkt_snapshot", 8'h02);
    L1_BUS = 32'h4433_2211;

    cap.delete();
    pulse_start(8'h07, 4'h3);
    wait_beats(5);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("drop_pulse", START_DROP, 1'b1);
    tick();
    chk("drop_clear", START_DROP, 1'b0);
    wait_done();
    check_lit("pkt_drop", 8'h03);

    cap.delete();
    pulse_start(8'h07, 4'h3);
    wait_done();
    chk("next_count", cap.size() > 1 ? cap[1] : 8'hxx, 8'h04);

    cap.delete();
    pulse_start(8'h07, 4'h3);
    wait_beats(8);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_valid", VALID, 1'b0);
    chk("midrst_busy", BUSY, 1'b0);
    cap.delete();
    pulse_start(8'h07, 4'h3);
    chk("post_rst_sop", SOP, 1'b1);
    wait_done();
    chk("post_rst_count", cap.size() > 1 ? cap[1] : 8'hxx, 8'h00);

    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int p = 0; p < 257; p++) begin
      cap.delete();
      pulse_start(8'h07, 4'h3);
      wait_done();
      seen[p] = (cap.size() > 1) ? cap[1] : 8'hxx;
    end
    chk("wrap_first", seen[0], 8'h00);
    chk("wrap_ff", seen[255], 8'hFF);
    chk("wrap_zero", seen[256], 8'h00);
    for (int p = 0; p < 257; p++) chk("wrap_seq", seen[p], p % 256);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
